// File: rtl/lbp_hist_if.sv
// Handshake bundle between the LBP producer, the histogram block and the
// feature/host sink. The master modport is the environment side (producer +
// sink). The slave modport is the histogram block itself.
interface lbp_hist_if #(
    parameter int CNT_W = 14
);
    logic             lbp_valid;
    logic [13:0]      lbp_addr;
    logic [7:0]       lbp_data;
    logic             finish;
    logic             clear;
    logic             hist_ready;
    logic             hist_valid;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic             hist_done;
    logic             pix_err;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, clear, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_done, pix_err
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, clear, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_done, pix_err
    );
endinterface

// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes for one 126x126 interior frame.
// It accumulates codes while the frame runs. After finish it streams every bin
// over a valid/ready handshake and then holds done until clear.
// pix_err is raised for any of these causes:
//   - the pixel count is wrong
//   - a border address is seen
//   - a bin saturates
//   - a pixel arrives while the bins are being dumped
module lbp_hist #(
    parameter int CNT_W     = 14,
    parameter int PIX_TOTAL = 15876
) (
    input  logic      clk_i,
    input  logic      reset_i,
    lbp_hist_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PIX_EXP  = CNT_W'(PIX_TOTAL);

    state_t           state_q;
    logic [CNT_W-1:0] bins_q [256];
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] pix_cnt_d;
    logic [8:0]       rd_ptr_q;
    logic             hist_valid_q;
    logic             hist_done_q;
    logic             pix_err_q;
    logic             pix_err_d;

    logic [CNT_W-1:0] bin_cur_s;
    logic [CNT_W-1:0] bin_nxt_d;
    logic             bin_sat_s;
    logic [6:0]       row_s;
    logic [6:0]       col_s;
    logic             addr_bad_s;
    logic             collecting_s;
    logic             accept_s;
    logic             fin_s;

    // Saturating bin/pixel increments and the sticky error next-state.
    always_comb begin
        row_s        = bus.lbp_addr[13:7];
        col_s        = bus.lbp_addr[6:0];
        addr_bad_s   = (row_s == 7'd0) || (row_s == 7'd127) ||
                       (col_s == 7'd0) || (col_s == 7'd127);
        collecting_s = (state_q == S_IDLE) || (state_q == S_ACC);
        accept_s     = collecting_s && bus.lbp_valid;
        fin_s        = collecting_s && bus.finish;

        bin_cur_s = bins_q[bus.lbp_data];
        bin_sat_s = (bin_cur_s == CNT_MAX);
        if (bin_sat_s) begin
            bin_nxt_d = bin_cur_s;
        end else begin
            bin_nxt_d = bin_cur_s + CNT_ONE;
        end

        // The pixel arriving with finish is counted before the total is judged.
        if (accept_s && (pix_cnt_q != CNT_MAX)) begin
            pix_cnt_d = pix_cnt_q + CNT_ONE;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end

        pix_err_d = pix_err_q
                  | (accept_s & (bin_sat_s | addr_bad_s))
                  | (fin_s & (pix_cnt_d != PIX_EXP))
                  | (bus.lbp_valid & (state_q == S_DUMP));
    end

    // The bin index is the read pointer itself. The count is read straight from the bin array.
    assign bus.hist_valid = hist_valid_q;
    assign bus.hist_bin   = hist_valid_q ? rd_ptr_q[7:0] : 8'd0;
    assign bus.hist_count = hist_valid_q ? bins_q[rd_ptr_q[7:0]] : CNT_ZERO;
    assign bus.hist_done  = hist_done_q;
    assign bus.pix_err    = pix_err_q;

    // Frame FSM: accumulate, dump with handshake, hold done until clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < 256; i++) begin
                bins_q[i] <= CNT_ZERO;
            end
            pix_cnt_q    <= CNT_ZERO;
            rd_ptr_q     <= 9'd0;
            hist_valid_q <= 1'b0;
            hist_done_q  <= 1'b0;
            pix_err_q    <= 1'b0;
        end else begin
            pix_err_q <= pix_err_d;
            case (state_q)
                S_IDLE, S_ACC: begin
                    if (accept_s) begin
                        bins_q[bus.lbp_data] <= bin_nxt_d;
                    end else begin
                        bins_q[bus.lbp_data] <= bin_cur_s;
                    end
                    pix_cnt_q <= pix_cnt_d;
                    if (bus.finish) begin
                        state_q      <= S_DUMP;
                        rd_ptr_q     <= 9'd0;
                        hist_valid_q <= 1'b1;
                    end else if (bus.lbp_valid) begin
                        state_q <= S_ACC;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_DUMP: begin
                    if (hist_valid_q && bus.hist_ready) begin
                        rd_ptr_q <= rd_ptr_q + 9'd1;
                        if (rd_ptr_q == 9'd255) begin
                            state_q      <= S_DONE;
                            hist_valid_q <= 1'b0;
                            hist_done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DUMP;
                        end
                    end else begin
                        rd_ptr_q <= rd_ptr_q;
                    end
                end
                S_DONE: begin
                    if (bus.clear) begin
                        for (int i = 0; i < 256; i++) begin
                            bins_q[i] <= CNT_ZERO;
                        end
                        pix_cnt_q   <= CNT_ZERO;
                        pix_err_q   <= 1'b0;
                        hist_done_q <= 1'b0;
                        rd_ptr_q    <= 9'd0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist. Each scenario drives a frame, drains the dump
// into got[] and compares against hand-computed expected bins and flags.
module tb_lbp_hist;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lbp_hist_if bus();

    lbp_hist dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int got [256];
    int ntrans;
    int ncyc;
    bit order_ok;
    bit stable_ok;
    bit timed_out;

    // Drive n pulses on successive cycles, then finish. Data mode 0 is all 0xFF, mode 1 is i mod 256, mode 2 is cdat.
    task automatic send_frame(input int n, input int mode, input logic [7:0] cdat,
                              input bit fin_last, input bit bad_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.lbp_valid = 1'b1;
            case (mode)
                0:       bus.lbp_data = 8'hFF;
                1:       bus.lbp_data = 8'(i % 256);
                default: bus.lbp_data = cdat;
            endcase
            bus.lbp_addr = {7'(1 + i / 126), 7'(1 + i % 126)};
            if (bad_first && i == 0) bus.lbp_addr = {7'd0, 7'd5};
            bus.finish = fin_last && (i == n - 1);
        end
        if (!fin_last) begin
            @(negedge clk);
            bus.lbp_valid = 1'b0;
            bus.finish    = 1'b1;
        end
        @(negedge clk);
        bus.lbp_valid = 1'b0;
        bus.finish    = 1'b0;
    endtask

    // Drain the dump into got[]; records transfer count, cycles, order and stall stability.
    task automatic run_dump(input bit rand_rdy);
        bit         prev_stall;
        bit         rdy;
        logic [7:0] pbin;
        logic [13:0] pcnt;
        for (int k = 0; k < 256; k++) got[k] = -1;
        ntrans = 0; ncyc = 0; order_ok = 1'b1; stable_ok = 1'b1;
        prev_stall = 1'b0; pbin = 8'd0; pcnt = 14'd0;
        while (bus.hist_done !== 1'b1 && ncyc < 4000) begin
            if (prev_stall && (bus.hist_valid !== 1'b1 || bus.hist_bin !== pbin ||
                               bus.hist_count !== pcnt)) stable_ok = 1'b0;
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.hist_ready = rdy;
            if (bus.hist_valid === 1'b1) begin
                pbin = bus.hist_bin;
                pcnt = bus.hist_count;
                prev_stall = !rdy;
                if (rdy) begin
                    if (bus.hist_bin !== 8'(ntrans)) order_ok = 1'b0;
                    got[bus.hist_bin] = int'(bus.hist_count);
                    ntrans++;
                end
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
            ncyc++;
        end
        bus.hist_ready = 1'b0;
        timed_out = (bus.hist_done !== 1'b1);
    endtask

    // One-cycle clear pulse.
    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.hist_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.hist_valid); end
        checks++; if (bus.hist_bin !== 8'd0) begin errors++; $display("FAIL reset_bin: got %0d want 0", bus.hist_bin); end
        checks++; if (bus.hist_count !== 14'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.hist_count); end
        checks++; if (bus.hist_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.hist_done); end
        checks++; if (bus.pix_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.pix_err); end
        reset = 1'b0;
    endtask

    task automatic test_all_ff();
        int nz;
        send_frame(15876, 0, 8'h00, 1'b0, 1'b0);
        run_dump(1'b0);
        nz = 0;
        for (int k = 0; k < 255; k++) if (got[k] != 0) nz++;
        checks++; if (timed_out) begin errors++; $display("FAIL ff_timeout: got done=%0b want 1", bus.hist_done); end
        checks++; if (ntrans != 256) begin errors++; $display("FAIL ff_transfers: got %0d want 256", ntrans); end
        checks++; if (ncyc != 256) begin errors++; $display("FAIL ff_latency: got %0d want 256", ncyc); end
        checks++; if (!order_ok) begin errors++; $display("FAIL ff_order: got out-of-order want 0..255"); end
        checks++; if (got[255] != 15876) begin errors++; $display("FAIL ff_bin255: got %0d want 15876", got[255]); end
        checks++; if (nz != 0) begin errors++; $display("FAIL ff_other_bins: got %0d nonzero want 0", nz); end
        checks++; if (bus.pix_err !== 1'b0) begin errors++; $display("FAIL ff_err: got %0b want 0", bus.pix_err); end
        checks++; if (bus.hist_valid !== 1'b0) begin errors++; $display("FAIL ff_valid_done: got %0b want 0", bus.hist_valid); end
        pulse_clear();
        checks++; if (bus.hist_done !== 1'b0) begin errors++; $display("FAIL ff_clear_done: got %0b want 0", bus.hist_done); end
    endtask

    task automatic test_mod256_stall();
        int bad;
        send_frame(15876, 1, 8'h00, 1'b0, 1'b0);
        run_dump(1'b1);
        bad = 0;
        for (int k = 0; k < 256; k++) if (got[k] != ((k < 4) ? 63 : 62)) bad++;
        checks++; if (timed_out) begin errors++; $display("FAIL mod_timeout: got done=%0b want 1", bus.hist_done); end
        checks++; if (ntrans != 256) begin errors++; $display("FAIL mod_transfers: got %0d want 256", ntrans); end
        checks++; if (!order_ok) begin errors++; $display("FAIL mod_order: got out-of-order want 0..255"); end
        checks++; if (!stable_ok) begin errors++; $display("FAIL mod_stall_stable: got changed want held"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL mod_bins: got %0d wrong bins (bin0=%0d bin4=%0d) want 0", bad, got[0], got[4]); end
        checks++; if (bus.pix_err !== 1'b0) begin errors++; $display("FAIL mod_err: got %0b want 0", bus.pix_err); end
        pulse_clear();
    endtask

    task automatic test_bad_addr();
        send_frame(15876, 2, 8'h01, 1'b0, 1'b1);
        run_dump(1'b0);
        checks++; if (got[1] != 15876) begin errors++; $display("FAIL badaddr_bin1: got %0d want 15876", got[1]); end
        checks++; if (bus.pix_err !== 1'b1) begin errors++; $display("FAIL badaddr_err: got %0b want 1", bus.pix_err); end
        pulse_clear();
        checks++; if (bus.pix_err !== 1'b0) begin errors++; $display("FAIL badaddr_clear_err: got %0b want 0", bus.pix_err); end
    endtask

    task automatic test_short_frame();
        int sum;
        send_frame(100, 1, 8'h00, 1'b1, 1'b0);
        run_dump(1'b0);
        sum = 0;
        for (int k = 0; k < 256; k++) sum += got[k];
        checks++; if (ntrans != 256) begin errors++; $display("FAIL short_transfers: got %0d want 256", ntrans); end
        checks++; if (got[99] != 1) begin errors++; $display("FAIL short_last_pixel: got %0d want 1", got[99]); end
        checks++; if (sum != 100) begin errors++; $display("FAIL short_sum: got %0d want 100", sum); end
        checks++; if (bus.pix_err !== 1'b1) begin errors++; $display("FAIL short_err: got %0b want 1", bus.pix_err); end
        pulse_clear();
    endtask

    task automatic test_empty_frame();
        int sum;
        send_frame(0, 2, 8'h00, 1'b0, 1'b0);
        checks++; if (bus.hist_valid !== 1'b1) begin errors++; $display("FAIL empty_dump: got valid=%0b want 1", bus.hist_valid); end
        run_dump(1'b0);
        sum = 0;
        for (int k = 0; k < 256; k++) sum += got[k];
        checks++; if (sum != 0) begin errors++; $display("FAIL empty_sum: got %0d want 0", sum); end
        checks++; if (bus.pix_err !== 1'b1) begin errors++; $display("FAIL empty_err: got %0b want 1", bus.pix_err); end
        pulse_clear();
    endtask

    task automatic test_reset_mid_dump();
        bit hit;
        send_frame(100, 2, 8'h10, 1'b0, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (bus.hist_valid === 1'b1 && bus.hist_bin === 8'd37) begin
                hit = 1'b1;
            end else begin
                bus.hist_ready = 1'b1;
                @(negedge clk);
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_reach_bin37: got bin %0d want 37", bus.hist_bin); end
        reset = 1'b1;
        bus.hist_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.hist_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.hist_valid); end
        checks++; if (bus.hist_bin !== 8'd0) begin errors++; $display("FAIL rst_bin: got %0d want 0", bus.hist_bin); end
        checks++; if (bus.pix_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", bus.pix_err); end
        checks++; if (bus.hist_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", bus.hist_done); end
        send_frame(50, 2, 8'h03, 1'b0, 1'b0);
        run_dump(1'b0);
        checks++; if (ntrans != 256) begin errors++; $display("FAIL rst_next_transfers: got %0d want 256", ntrans); end
        checks++; if (got[3] != 50) begin errors++; $display("FAIL rst_next_bin3: got %0d want 50", got[3]); end
        checks++; if (got[16] != 0) begin errors++; $display("FAIL rst_next_bin16: got %0d want 0", got[16]); end
        pulse_clear();
    endtask

    task automatic test_second_frame();
        send_frame(30, 2, 8'h05, 1'b0, 1'b0);
        run_dump(1'b0);
        checks++; if (got[5] != 30) begin errors++; $display("FAIL f1_bin5: got %0d want 30", got[5]); end
        pulse_clear();
        checks++; if (bus.hist_done !== 1'b0) begin errors++; $display("FAIL f2_done_after_clear: got %0b want 0", bus.hist_done); end
        bus.clear = 1'b1;
        send_frame(20, 2, 8'h06, 1'b0, 1'b0);
        bus.clear = 1'b0;
        checks++; if (bus.hist_done !== 1'b0) begin errors++; $display("FAIL f2_done_early: got %0b want 0", bus.hist_done); end
        run_dump(1'b0);
        checks++; if (got[5] != 0) begin errors++; $display("FAIL f2_carry_bin5: got %0d want 0", got[5]); end
        checks++; if (got[6] != 20) begin errors++; $display("FAIL f2_bin6: got %0d want 20", got[6]); end
        checks++; if (bus.hist_done !== 1'b1) begin errors++; $display("FAIL f2_done: got %0b want 1", bus.hist_done); end
        pulse_clear();
    endtask

    initial begin
        bus.lbp_valid  = 1'b0;
        bus.lbp_addr   = 14'd0;
        bus.lbp_data   = 8'd0;
        bus.finish     = 1'b0;
        bus.clear      = 1'b0;
        bus.hist_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_all_ff();
        test_mod256_stall();
        test_bad_addr();
        test_short_frame();
        test_empty_frame();
        test_reset_mid_dump();
        test_second_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
